// File: rtl/trap_control_unit.sv
// Supervisor trap controller: trap CSRs, trap/return FSM and PC redirect.
// Optional vectored interrupts with TRAP_VECTORED_EN; csr_rdata is a combinational read.
module trap_control_unit #(
  parameter logic [31:0] RESET_STVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        int_signal,
  input  logic [7:0]  scause_in,
  input  logic        ecall,
  input  logic        mret,
  input  logic [31:0] epc_in,
  input  logic        ext_int,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_active
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SAVE = 2'd1;
  localparam logic [1:0] JUMP = 2'd2;
  localparam logic [1:0] RET  = 2'd3;

  localparam logic [11:0] A_SSTATUS = 12'h100;
  localparam logic [11:0] A_STVEC   = 12'h105;
  localparam logic [11:0] A_SEPC    = 12'h141;
  localparam logic [11:0] A_SCAUSE  = 12'h142;

  logic [1:0]  state;
  logic [31:0] stvec;
  logic [31:0] sepc;
  logic [31:0] target;
  logic [7:0]  scause;
  logic        sie;
  logic        spie;

  logic        req;
  logic        exc;
  logic        irq;
  logic        take_trap;
  logic        take_int;
  logic        take_ret;
  logic [7:0]  cause;
  logic [31:0] base;
  logic [31:0] vec_pc;
  logic [31:0] stvec_wr;

  assign req = (state == IDLE) & id_valid;
  assign exc = int_signal | ecall;
  assign irq = ext_int & sie;

  assign take_trap = req & (exc | irq);
  assign take_int  = req & ~exc & irq;
  assign take_ret  = req & ~exc & ~irq & mret;

  always_comb begin
    cause = scause_in;
    if (take_int)
      cause = 8'h89;
    else if (ecall)
      cause = 8'h08;
  end

  assign base = {stvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign vec_pc = (take_int & stvec[0])
                ? base + {23'b0, cause[6:0], 2'b00}
                : base;
  assign stvec_wr = {csr_wdata[31:2], 1'b0, csr_wdata[0]};
`else
  assign vec_pc   = base;
  assign stvec_wr = {csr_wdata[31:2], 2'b00};
`endif

  // Target is latched at entry so a same-edge stvec write
  // only affects later traps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      stvec  <= RESET_STVEC;
      sepc   <= 32'h0;
      scause <= 8'h0;
      sie    <= 1'b0;
      spie   <= 1'b0;
      target <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (take_trap)
            state <= SAVE;
          else if (take_ret)
            state <= RET;
        end
        SAVE:    state <= JUMP;
        default: state <= IDLE;
      endcase

      if (take_trap) begin
        sepc   <= epc_in;
        scause <= cause;
        spie   <= sie;
        sie    <= 1'b0;
        target <= vec_pc;
      end else if (take_ret) begin
        sie  <= spie;
        spie <= 1'b1;
      end else if (csr_we) begin
        if (csr_addr == A_SSTATUS) begin
          sie  <= csr_wdata[1];
          spie <= csr_wdata[5];
        end
        if (csr_addr == A_SEPC)
          sepc <= csr_wdata;
        if (csr_addr == A_SCAUSE)
          scause <= {csr_wdata[31], csr_wdata[6:0]};
      end

      if (csr_we && csr_addr == A_STVEC)
        stvec <= stvec_wr;
    end
  end

  always_comb begin
    case (csr_addr)
      A_SSTATUS: csr_rdata = {26'b0, spie, 3'b0, sie, 1'b0};
      A_STVEC:   csr_rdata = stvec;
      A_SEPC:    csr_rdata = sepc;
      A_SCAUSE:  csr_rdata = {scause[7], 24'b0, scause[6:0]};
      default:   csr_rdata = 32'h0;
    endcase
  end

  always_comb begin
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state)
      SAVE: begin
        flush = 1'b1;
        stall = 1'b1;
      end
      JUMP: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
      end
      RET: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = {sepc[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign trap_active = (state != IDLE);

endmodule

// File: tb/tb_trap_control_unit.sv
// Testbench for trap_control_unit: directed vectors, redirect scoreboard.
// Expected redirect targets are queued; a monitor checks every redirect.
module tb_trap_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        int_signal = 1'b0;
  logic [7:0]  scause_in = 8'h0;
  logic        ecall = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] epc_in = 32'h0;
  logic        ext_int = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic [31:0] csr_rdata;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_active;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  trap_control_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .int_signal(int_signal), .scause_in(scause_in),
    .ecall(ecall), .mret(mret), .epc_in(epc_in),
    .ext_int(ext_int), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .flush(flush), .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_active(trap_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every redirect must match the next queued target.
  always @(negedge clk) begin
    if (redirect_valid === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL redirect_unexpected: got %h expected none",
                 redirect_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (redirect_pc === e && flush === 1'b1) pass_cnt++;
        else $display("FAIL redirect_pc: got %h flush %b expected %h",
                      redirect_pc, flush, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; int_signal = 0; scause_in = 0;
    ecall = 0; mret = 0; ext_int = 0; csr_we = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 0;
  endtask

  task automatic rd(input string name, input logic [11:0] a,
                    input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  // Present one request for one edge; returns 1ns after that edge.
  task automatic req(input logic ec, input logic ig,
                     input logic mr, input logic ei,
                     input logic [7:0] sc, input logic [31:0] epc);
    id_valid = 1; ecall = ec; int_signal = ig; mret = mr;
    ext_int = ei; scause_in = sc; epc_in = epc;
    step();
    clr();
  endtask

  initial begin
    clr();
    step();
    step();
    rst = 0;
    step();

    // Reset state
    rd("rst_stvec", 12'h105, 32'h100);
    rd("rst_sstatus", 12'h100, 32'h0);
    chk("rst_outs", {28'b0, flush, stall, redirect_valid, trap_active}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);

    // Ecall
    exp_q.push_back(32'h100);
    req(1, 0, 0, 0, 8'h00, 32'h1004);
    chk("ecall_save", {29'b0, flush, stall, redirect_valid}, 32'h6);
    chk("ecall_active", {31'b0, trap_active}, 32'h1);
    step();
    chk("ecall_jump_nostall", {30'b0, flush, stall}, 32'h2);
    step();
    chk("ecall_idle", {31'b0, trap_active}, 32'h0);
    rd("ecall_sepc", 12'h141, 32'h1004);
    rd("ecall_scause", 12'h142, 32'h8);
    rd("ecall_sstatus", 12'h100, 32'h0);

    // Misaligned PC preserved in sepc
    exp_q.push_back(32'h100);
    req(0, 1, 0, 0, 8'h00, 32'h1001);
    step();
    step();
    rd("mis_sepc", 12'h141, 32'h1001);
    rd("mis_scause", 12'h142, 32'h0);

    // Interrupt with SIE=1
    csr_wr(12'h100, 32'h2);
    rd("sie_wr", 12'h100, 32'h2);
    exp_q.push_back(32'h100);
    req(0, 0, 0, 1, 8'h00, 32'h2000);
    step();
    step();
    rd("int_scause", 12'h142, 32'h8000_0009);
    rd("int_sstatus", 12'h100, 32'h20);
    rd("int_sepc", 12'h141, 32'h2000);

    // MRET: redirect at E+1, SIE<=SPIE, SPIE<=1
    exp_q.push_back(32'h2000);
    req(0, 0, 1, 0, 8'h00, 32'h0);
    chk("ret_outs", {29'b0, flush, stall, redirect_valid}, 32'h5);
    step();
    chk("ret_idle", {31'b0, trap_active}, 32'h0);
    rd("ret_sstatus", 12'h100, 32'h22);

    // SIE=0: interrupt held, nothing happens
    csr_wr(12'h100, 32'h20);
    id_valid = 1; ext_int = 1;
    step();
    step();
    chk("gated_int", {31'b0, trap_active}, 32'h0);
    clr();

    // Simultaneous events, then ecall during SAVE ignored
    csr_wr(12'h100, 32'h2);
    exp_q.push_back(32'h100);
    req(0, 1, 1, 1, 8'h02, 32'h3000);
    id_valid = 1; ecall = 1; epc_in = 32'h3100;
    step();
    clr();
    step();
    rd("sim_scause", 12'h142, 32'h2);
    rd("sim_sepc", 12'h141, 32'h3000);
    rd("sim_sstatus", 12'h100, 32'h20);

    // stvec write and vectored interrupt
    csr_wr(12'h105, 32'h201);
`ifdef TRAP_VECTORED_EN
    rd("stvec_rd", 12'h105, 32'h201);
    exp_q.push_back(32'h224);
`else
    rd("stvec_rd", 12'h105, 32'h200);
    exp_q.push_back(32'h200);
`endif
    csr_wr(12'h100, 32'h2);
    req(0, 0, 0, 1, 8'h00, 32'h4000);
    step();
    step();

    // stvec write on the trap edge: this jump uses old base
    exp_q.push_back(32'h200);
    csr_we = 1; csr_addr = 12'h105; csr_wdata = 32'h300;
    req(1, 0, 0, 0, 8'h00, 32'h4400);
    step();
    step();
    rd("stvec_new", 12'h105, 32'h300);

    // Reset during SAVE
    req(1, 0, 0, 0, 8'h00, 32'h5000);
    chk("pre_rst_save", {31'b0, stall}, 32'h1);
    #1 rst = 1;
    #1;
    chk("rst_mid_outs",
        {28'b0, flush, stall, redirect_valid, trap_active}, 32'h0);
    rd("rst_mid_sepc", 12'h141, 32'h0);
    rd("rst_mid_stvec", 12'h105, 32'h100);
    step();
    rst = 0;
    step();
    step();

    chk("queue_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
